// File: rtl/risc_pkg.sv
// Shared encodings for the write-back / branch stage.
// Holds MD/BS codes, the squash state type and the datapath width.
package risc_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    MD_F   = 2'b00,
    MD_MEM = 2'b01,
    MD_SLT = 2'b10,
    MD_RSV = 2'b11
  } md_e;

  typedef enum logic [1:0] {
    BS_SEQ  = 2'b00,
    BS_COND = 2'b01,
    BS_JR   = 2'b10,
    BS_BR   = 2'b11
  } bs_e;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    KILL2 = 2'b01,
    KILL1 = 2'b10
  } sq_state_e;

  function automatic logic [DW-1:0] wb_sel(
    input logic [1:0]    md,
    input logic [DW-1:0] f,
    input logic [DW-1:0] mem,
    input logic          slt
  );
    logic [DW-1:0] r;
    r = f;
    unique case (md)
      MD_F:    r = f;
      MD_MEM:  r = mem;
      MD_SLT:  r = {{(DW-1){1'b0}}, slt};
      default: r = f;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision: bs, ps, z, bra, raa in;
// taken and target out. Only meaningful while the stage is in RUN.
module branch_resolve
  import risc_pkg::*;
#(
  parameter int W = DW
) (
  input  logic [1:0]   bs,
  input  logic         ps,
  input  logic         z,
  input  logic [W-1:0] bra,
  input  logic [W-1:0] raa,
  output logic         taken,
  output logic [W-1:0] target
);

  always_comb begin
    taken  = 1'b0;
    target = bra;
    unique case (bs)
      BS_SEQ:  taken = 1'b0;
      BS_COND: taken = z ^ ps;
      BS_JR: begin
        taken  = 1'b1;
        target = raa;
      end
      BS_BR:   taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_branch_unit.sv
// Write-back register, PC owner and two-slot branch squash FSM.
// Ports: CLOCK (negedge), RESET (sync, low), execute results in;
// PC/PC_1/RW_wb/DA_wb/BUS_D/FLUSH/BR_TAKEN out.
// BRANCH_STATS_EN adds saturating BR_COUNT and KILL_COUNT outputs.
// PC_W must equal the 32-bit datapath width.
module wb_branch_unit
  import risc_pkg::*;
#(
  parameter int             PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            RW,
  input  logic [4:0]      DA,
  input  logic [1:0]      MD,
  input  logic            BS_one,
  input  logic            BS_zero,
  input  logic            PS,
  input  logic            Z,
  input  logic            VxorN,
  input  logic [DW-1:0]   F,
  input  logic [DW-1:0]   Data_Out,
  input  logic [PC_W-1:0] BrA,
  input  logic [PC_W-1:0] RAA,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PC_1,
  output logic            RW_wb,
  output logic [4:0]      DA_wb,
  output logic [DW-1:0]   BUS_D,
  output logic            FLUSH,
  output logic            BR_TAKEN
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     BR_COUNT,
  output logic [15:0]     KILL_COUNT
`endif
);

  sq_state_e       state;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            run;
  logic            take;

  branch_resolve #(.W(PC_W)) u_br (
    .bs     ({BS_one, BS_zero}),
    .ps     (PS),
    .z      (Z),
    .bra    (BrA),
    .raa    (RAA),
    .taken  (taken),
    .target (target)
  );

  assign PC_1  = PC + PC_W'(1);
  assign FLUSH = (state != RUN);
  assign run   = (state == RUN);
  // wrong-path slots never redirect
  assign take  = run & taken;

  always_ff @(negedge CLOCK) begin
    if (!RESET) begin
      state    <= RUN;
      PC       <= RESET_PC;
      RW_wb    <= 1'b0;
      DA_wb    <= '0;
      BUS_D    <= '0;
      BR_TAKEN <= 1'b0;
    end else begin
      DA_wb    <= DA;
      BUS_D    <= wb_sel(MD, F, Data_Out, VxorN);
      RW_wb    <= run & RW;
      BR_TAKEN <= take;
      PC       <= take ? target : PC_1;
      unique case (state)
        RUN:     state <= take ? KILL2 : RUN;
        KILL2:   state <= KILL1;
        KILL1:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(negedge CLOCK) begin
    if (!RESET) begin
      BR_COUNT   <= '0;
      KILL_COUNT <= '0;
    end else begin
      if (take && BR_COUNT != 16'hFFFF)
        BR_COUNT <= BR_COUNT + 16'd1;
      if (!run && KILL_COUNT != 16'hFFFF)
        KILL_COUNT <= KILL_COUNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_branch_unit.sv
// Bench for wb_branch_unit: reference model plus directed
// literals and randomized traffic, one compare per output per cycle.
module tb_wb_branch_unit;

  logic        CLOCK = 1'b0;
  logic        RESET, RW, BS_one, BS_zero, PS, Z, VxorN;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic [31:0] F, Data_Out, BrA, RAA;
  logic [31:0] PC, PC_1, BUS_D;
  logic [4:0]  DA_wb;
  logic        RW_wb, FLUSH, BR_TAKEN;
`ifdef BRANCH_STATS_EN
  logic [15:0] BR_COUNT, KILL_COUNT;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  wb_branch_unit #(.PC_W(32), .RESET_PC(32'h100)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .MD(MD),
    .BS_one(BS_one), .BS_zero(BS_zero), .PS(PS), .Z(Z),
    .VxorN(VxorN), .F(F), .Data_Out(Data_Out), .BrA(BrA),
    .RAA(RAA), .PC(PC), .PC_1(PC_1), .RW_wb(RW_wb),
    .DA_wb(DA_wb), .BUS_D(BUS_D), .FLUSH(FLUSH),
    .BR_TAKEN(BR_TAKEN)
`ifdef BRANCH_STATS_EN
    , .BR_COUNT(BR_COUNT), .KILL_COUNT(KILL_COUNT)
`endif
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference model: counts remaining squash slots
  bit          m_valid = 0;
  logic [31:0] m_pc, m_busd;
  logic [4:0]  m_da;
  logic        m_rw, m_brt;
  int          m_kills;
  int          m_brc, m_killc;

  always @(negedge CLOCK) begin
    int  bs;
    bit  tk;
    logic [31:0] tg;
    if (!RESET) begin
      m_valid = 1;
      m_pc = 32'h100; m_busd = 0; m_da = 0;
      m_rw = 0; m_brt = 0; m_kills = 0;
      m_brc = 0; m_killc = 0;
    end else begin
      bs = {30'd0, BS_one, BS_zero};
      tk = (bs == 2) || (bs == 3) || (bs == 1 && Z != PS);
      tg = (bs == 2) ? RAA : BrA;
      if (MD == 2'd1) m_busd = Data_Out;
      else if (MD == 2'd2) m_busd = {31'd0, VxorN};
      else m_busd = F;
      m_da = DA;
      if (m_kills > 0) begin
        m_rw = 0; m_brt = 0;
        m_pc = m_pc + 1;
        m_kills--;
        if (m_killc < 65535) m_killc++;
      end else begin
        m_rw = RW; m_brt = tk;
        if (tk) begin
          m_pc = tg; m_kills = 2;
          if (m_brc < 65535) m_brc++;
        end else m_pc = m_pc + 1;
      end
    end
  end

  always @(posedge CLOCK) begin
    if (m_valid) begin
      check("pc", PC, m_pc);
      check("pc_1", PC_1, m_pc + 32'd1);
      check("rw_wb", {31'd0, RW_wb}, {31'd0, m_rw});
      check("da_wb", {27'd0, DA_wb}, {27'd0, m_da});
      check("bus_d", BUS_D, m_busd);
      check("flush", {31'd0, FLUSH}, {31'd0, m_kills != 0});
      check("br_taken", {31'd0, BR_TAKEN}, {31'd0, m_brt});
`ifdef BRANCH_STATS_EN
      check("br_count", {16'd0, BR_COUNT}, m_brc);
      check("kill_count", {16'd0, KILL_COUNT}, m_killc);
`endif
    end
  end

  task automatic cyc();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic idle();
    RW = 0; DA = 0; MD = 0; BS_one = 0; BS_zero = 0;
    PS = 0; Z = 0; VxorN = 0; F = 0; Data_Out = 0;
    BrA = 0; RAA = 0;
  endtask

  task automatic set_bs(input logic [1:0] b);
    {BS_one, BS_zero} = b;
  endtask

  // jump to t, then ride out both squash slots
  task automatic go(input logic [31:0] t);
    idle(); set_bs(2'b10); RAA = t;
    cyc();
    set_bs(2'b00);
    cyc(); cyc();
  endtask

  initial begin
    RESET = 0; idle();
    cyc(); cyc();
    check("rst_pc", PC, 32'h100);
    check("rst_rw", {31'd0, RW_wb}, 32'd0);
    check("rst_flush", {31'd0, FLUSH}, 32'd0);
    check("rst_busd", BUS_D, 32'd0);
    RESET = 1;
    cyc(); check("pc_101", PC, 32'h101);
    cyc(); check("pc_102", PC, 32'h102);

    RW = 1; DA = 5; MD = 0; F = 32'hDEADBEEF;
    cyc();
    check("wb_rw", {31'd0, RW_wb}, 32'd1);
    check("wb_da", {27'd0, DA_wb}, 32'd5);
    check("wb_f", BUS_D, 32'hDEADBEEF);
    MD = 1; Data_Out = 32'h1234;
    cyc(); check("wb_mem", BUS_D, 32'h1234);
    MD = 2; VxorN = 1;
    cyc(); check("wb_slt", BUS_D, 32'h1);
    MD = 3; F = 32'h55;
    cyc(); check("wb_rsv", BUS_D, 32'h55);

    go(32'h1E);
    check("at_20", PC, 32'h20);
    idle(); set_bs(2'b01); BrA = 32'h40; RW = 1; Z = 1;
    cyc();
    check("cb_pc", PC, 32'h40);
    check("cb_pulse", {31'd0, BR_TAKEN}, 32'd1);
    check("cb_flush", {31'd0, FLUSH}, 32'd1);
    check("cb_rw", {31'd0, RW_wb}, 32'd1);
    set_bs(2'b00);
    cyc();
    check("k2_pc", PC, 32'h41);
    check("k2_rw", {31'd0, RW_wb}, 32'd0);
    check("k2_pulse", {31'd0, BR_TAKEN}, 32'd0);
    cyc();
    check("k1_rw", {31'd0, RW_wb}, 32'd0);
    check("k1_flush", {31'd0, FLUSH}, 32'd0);
    cyc();
    check("run_rw", {31'd0, RW_wb}, 32'd1);

    go(32'h1E);
    idle(); set_bs(2'b01); BrA = 32'h40; Z = 0;
    cyc();
    check("nt_pc", PC, 32'h21);
    check("nt_flush", {31'd0, FLUSH}, 32'd0);

    idle(); set_bs(2'b10); RAA = 32'h80;
    cyc(); check("j_pc", PC, 32'h80);
    set_bs(2'b11); BrA = 32'h10; RW = 1;
    cyc();
    check("ign_pc", PC, 32'h81);
    check("ign_rw", {31'd0, RW_wb}, 32'd0);
    idle();
    cyc();
    check("ign_pc2", PC, 32'h82);
    check("ign_flush", {31'd0, FLUSH}, 32'd0);

    idle(); set_bs(2'b10); RAA = 32'h300;
    cyc(); set_bs(2'b00);
    cyc();
    check("in_k1", {31'd0, FLUSH}, 32'd1);
    RESET = 0;
    cyc();
    check("rk_pc", PC, 32'h100);
    check("rk_flush", {31'd0, FLUSH}, 32'd0);
    RESET = 1;

    go(32'hFFFF_FFFD);
    check("wrap_pre", PC, 32'hFFFF_FFFF);
    check("wrap_pc1", PC_1, 32'h0);
    cyc();
    check("wrap_pc", PC, 32'h0);

    for (int i = 0; i < 400; i++) begin
      RESET    = ($urandom_range(0, 39) != 0);
      RW       = 1'($urandom);
      DA       = 5'($urandom);
      MD       = 2'($urandom);
      set_bs(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
      PS       = 1'($urandom);
      Z        = 1'($urandom);
      VxorN    = 1'($urandom);
      F        = $urandom;
      Data_Out = $urandom;
      BrA      = $urandom;
      RAA      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE
                                              : $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_branch_unit.md
Name: wb_branch_unit

Overview:
- Consumer end of the execute-stage output interface.
- Latches execute results into the write-back pipeline register and selects register-file write data (BUS_D).
- Resolves branches/jumps and owns the program counter.
- Runs a squash state machine that bubbles the two wrong-path instructions following a taken branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC and address width. Must equal the datapath width.

Ports:
- CLOCK  in  1  Single clock; all state updates on negedge CLOCK, matching the other pipeline stage registers.
- RESET  in  1  Synchronous, active-low reset.
- RW  in  1  Register write enable from execute.
- DA  in  5  Destination register address from execute.
- MD  in  2  Write-back mux select from execute.
- BS_one  in  1  Branch select bit 1.
- BS_zero  in  1  Branch select bit 0.
- PS  in  1  Branch polarity (0 = branch on zero, 1 = branch on non-zero).
- Z  in  1  Zero flag from the function unit.
- VxorN  in  1  Set-less-than result.
- F  in  32  Function unit result.
- Data_Out  in  32  Data memory read data.
- BrA  in  32  PC-relative branch target.
- RAA  in  32  Register jump target.
- PC  out  32  Current PC to the fetch stage.
- PC_1  out  32  PC+1 (combinational from PC) for link and relative-address use.
- RW_wb  out  1  Registered register-file write enable.
- DA_wb  out  5  Registered write address.
- BUS_D  out  32  Registered write data.
- FLUSH  out  1  High while squashing; upstream stages clear MW/RW of the instructions they hold.
- BR_TAKEN  out  1  One-cycle pulse registered on the edge a branch is taken.

Behaviour:
- Reset: on a negedge with RESET=0:
  - PC=RESET_PC, state=RUN.
  - RW_wb=0, DA_wb=0, BUS_D=0, BR_TAKEN=0, FLUSH=0.
  - Reset dominates every other event, including reset in KILL2/KILL1 mid-squash.
- States: RUN, KILL2, KILL1. FLUSH = (state != RUN), decoded directly from the state register.
- Branch decode in RUN, from BS={BS_one,BS_zero}:
  - 00: not taken.
  - 01: taken iff (Z ^ PS), target BrA.
  - 10: taken, target RAA.
  - 11: taken, target BrA.
- PC update: taken → PC <= target; otherwise PC <= PC+1, wrapping mod 2^32 (32'hFFFF_FFFF → 0).
- Transitions:
  - RUN + taken → KILL2, BR_TAKEN <= 1.
  - KILL2 → KILL1 unconditionally.
  - KILL1 → RUN unconditionally.
  - BR_TAKEN <= 0 on every other edge.
- In KILL2/KILL1 the inputs are a wrong-path instruction:
  - RW_wb <= 0.
  - BS ignored; no re-branch, even if the instruction is itself a branch.
  - PC <= PC+1.
- Write-back register (1-cycle latency), DA_wb <= DA and:
  - MD=00 → BUS_D <= F.
  - MD=01 → BUS_D <= Data_Out.
  - MD=10 → BUS_D <= {31'b0, VxorN}.
  - MD=11 → reserved; BUS_D <= F.
- RW_wb <= RW only in RUN; a branch instruction in RUN writes back normally if its RW=1.
- Branch in the first RUN cycle after KILL1 is honored normally (back-to-back branches separated by exactly two kills).

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs BR_COUNT[15:0] and KILL_COUNT[15:0].
  - BR_COUNT increments on each taken branch.
  - KILL_COUNT increments on each KILL-state edge.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package risc_pkg:
  - MD encodings MD_F, MD_MEM, MD_SLT.
  - BS encodings BS_SEQ, BS_COND, BS_JR, BS_BR.
  - Squash state enum {RUN, KILL2, KILL1}.
  - Data width 32.
- Sub-module branch_resolve: combinational; inputs BS, PS, Z, BrA, RAA; outputs taken and target. Instantiated once.

Test Plan:
- Reset: hold RESET=0 with RESET_PC=32'h100 for 2 edges, then release → PC=0x100, then 0x101 and 0x102 on successive edges; RW_wb=0, FLUSH=0.
- Write-back mux: RW=1, DA=5:
  - MD=00, F=0xDEADBEEF → next edge RW_wb=1, DA_wb=5, BUS_D=0xDEADBEEF.
  - MD=01, Data_Out=0x1234 → BUS_D=0x1234.
  - MD=10, VxorN=1 → BUS_D=1.
- Conditional branch at PC=0x20, BrA=0x40, BS=01:
  - PS=0, Z=1 → PC=0x40, BR_TAKEN pulse, FLUSH high 2 cycles, RW_wb=0 for those 2 cycles.
  - PS=0, Z=0 → PC=0x21, no flush.
- Jump BS=10, RAA=0x80 followed by a BS=11 branch (BrA=0x10, RW=1) in KILL2 → PC=0x80, 0x81, 0x82; second branch ignored, RW_wb=0.
- RESET asserted while in KILL1 → next state RUN, PC=RESET_PC, FLUSH=0; PC=0xFFFFFFFF with BS=00 → PC=0.
